jtpang_ioctl_tx: RTL

- Transmitter side of the ioctl download/upload interface that the Pang game top receives.
- Download: takes a byte stream from the loader front end and emits ioctl_addr/ioctl_dout/ioctl_wr writes with SDRAM-friendly pacing, framed by downloading/dwnld_busy.
- Upload: reads the NVRAM back over ioctl_din with ioctl_ram asserted and streams the bytes out.
- Sits between the HPS/SPI loader and the game top; used in simulation and on the MiST-style targets.

---
 rtl/jtpang_ioctl_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/jtpang_ioctl_tx.sv
// ioctl transmitter for the Pang top: paces loader bytes into ioctl writes
// and streams NVRAM contents back out through ioctl_din during upload.
module jtpang_ioctl_tx #(
    parameter int WR_GAP  = 4,
    parameter int DIN_LAT = 2,
    parameter int NV_AW   = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_dl,
    input  logic             start_ul,
    input  logic [24:0]      dl_len,
    input  logic [NV_AW:0]   ul_len,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [7:0]       u_data,
    output logic             u_valid,
    input  logic             u_ready,
    output logic [24:0]      ioctl_addr,
    output logic [7:0]       ioctl_dout,
    output logic             ioctl_wr,
    output logic             ioctl_ram,
    input  logic [7:0]       ioctl_din,
    output logic             downloading,
    input  logic             dwnld_busy,
    output logic             done
);

    typedef enum logic [3:0] {
        IDLE, DL_WAIT, DL_WR, DL_GAP, DL_FLUSH, UL_ADDR, UL_LAT, UL_OUT, FIN
    } state_t;

    localparam logic [4:0]     GAP_LIM = 5'(WR_GAP);
    localparam logic [2:0]     LAT_LIM = 3'(DIN_LAT);
    localparam logic [NV_AW:0] UL_MAX  = {1'b1, {NV_AW{1'b0}}};

    state_t             state, state_nxt;
    logic [24:0]        rem_cnt;
    logic [3:0]         gap_cnt;
    logic [2:0]         lat_cnt;
    logic [NV_AW:0]     ul_len_c;
    logic [NV_AW-1:0]   ul_addr_nxt;
    logic               gap_done, lat_done, last_byte;

    // WR -> GAP -> WAIT -> WR already spends three cycles, so the gap only
    // has to cover whatever WR_GAP asks for beyond that.
    assign gap_done    = ({1'b0, gap_cnt} + 5'd3) >= GAP_LIM;
    assign lat_done    = lat_cnt >= LAT_LIM;
    assign last_byte   = rem_cnt == 25'd1;
    assign ul_addr_nxt = ioctl_addr[NV_AW-1:0] + NV_AW'(1);
    assign ul_len_c    = (ul_len[NV_AW] && (|ul_len[NV_AW-1:0])) ? UL_MAX : ul_len;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        ioctl_wr  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start_dl)      state_nxt = (|dl_len) ? DL_WAIT : FIN;
                else if (start_ul) state_nxt = (|ul_len) ? UL_ADDR : FIN;
            end
            DL_WAIT: begin
                s_ready = 1'b1;
                if (s_valid) state_nxt = DL_WR;
            end
            DL_WR: begin
                ioctl_wr  = 1'b1;
                state_nxt = DL_GAP;
            end
            DL_GAP:   if (gap_done) state_nxt = last_byte ? DL_FLUSH : DL_WAIT;
            DL_FLUSH: if (!dwnld_busy) state_nxt = FIN;
            UL_ADDR:  state_nxt = UL_LAT;
            UL_LAT:   if (lat_done) state_nxt = UL_OUT;
            UL_OUT:   if (u_ready) state_nxt = last_byte ? FIN : UL_ADDR;
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_cnt     <= '0;
            gap_cnt     <= '0;
            lat_cnt     <= '0;
            ioctl_addr  <= '0;
            ioctl_dout  <= '0;
            ioctl_ram   <= 1'b0;
            downloading <= 1'b0;
            u_data      <= '0;
            u_valid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_dl) begin
                        rem_cnt     <= dl_len;
                        ioctl_addr  <= '0;
                        downloading <= |dl_len;
                    end else if (start_ul) begin
                        rem_cnt    <= {{(24-NV_AW){1'b0}}, ul_len_c};
                        ioctl_addr <= '0;
                        ioctl_ram  <= |ul_len;
                    end
                end
                DL_WAIT: if (s_valid) ioctl_dout <= s_data;
                DL_WR:   gap_cnt <= '0;
                DL_GAP: begin
                    if (gap_done) begin
                        ioctl_addr <= ioctl_addr + 25'd1;
                        rem_cnt    <= rem_cnt - 25'd1;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                DL_FLUSH: if (!dwnld_busy) downloading <= 1'b0;
                UL_ADDR:  lat_cnt <= 3'd1;
                UL_LAT: begin
                    if (lat_done) begin
                        u_data  <= ioctl_din;
                        u_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                // Upload addresses stay inside the NVRAM window; upper bits held at 0.
                UL_OUT: begin
                    if (u_ready) begin
                        u_valid    <= 1'b0;
                        ioctl_addr <= {{(25-NV_AW){1'b0}}, ul_addr_nxt};
                        rem_cnt    <= rem_cnt - 25'd1;
                        if (last_byte) ioctl_ram <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
